// File: rtl/lane_sequencer_if.sv
// Command, vector-memory and lane-datapath signals shared by lane_sequencer and its environment.
// master: decode stage / memory / lanes side; slave: the sequencer itself.
interface lane_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);

  // command / handshake
  logic              start;
  logic [1:0]        op;
  logic              size;
  logic [15:0]       srcb;
  logic [1:0]        idx;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] len;
  logic              busy;
  logic              done;

  // vector memory
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [63:0]       mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [63:0]       mem_wr_data;

  // lane datapath
  logic [2:0]        lane_ctrl;
  logic [63:0]       lane_rv;
  logic [15:0]       lane_srcb;
  logic [1:0]        lane_idx;
  logic [63:0]       lane_res;

  modport master (
    output start, op, size, srcb, idx, src_addr, dst_addr, len,
    output mem_rd_data, lane_res,
    input  busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  lane_ctrl, lane_rv, lane_srcb, lane_idx
  );

  modport slave (
    input  start, op, size, srcb, idx, src_addr, dst_addr, len,
    input  mem_rd_data, lane_res,
    output busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output lane_ctrl, lane_rv, lane_srcb, lane_idx
  );

endinterface

// File: rtl/lane_sequencer.sv
// Streams len words from vector memory through the lanes and back, one word per cycle,
// using a read -> execute -> write pipeline. LANE_SEQ_CNT_EN adds the words_done counter.
module lane_sequencer #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
`ifdef LANE_SEQ_CNT_EN
  output logic [31:0]         words_done,
`endif
  lane_sequencer_if.slave     bus
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned SRCB_W = 16;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                drain_q;
  logic                rd_en_q;
  logic                rd_vld_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   remain_q;
  logic [ADDR_W-1:0]   dst_ptr_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [SRCB_W-1:0]   srcb_q;
  logic [IDX_W-1:0]    idx_q;

  // Sequencing FSM plus the execute/write pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      remain_q  <= '0;
      dst_ptr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ctrl_q    <= '0;
      srcb_q    <= '0;
      idx_q     <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_vld_q <= rd_en_q;
      wr_en_q  <= rd_vld_q;

      // Word read last cycle is on lane_rv now; capture the lane result for write-back.
      if (rd_vld_q) begin
        wr_addr_q <= dst_ptr_q;
        wr_data_q <= bus.lane_res;
        dst_ptr_q <= dst_ptr_q + ADDR_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            ctrl_q    <= {bus.op, bus.size};
            srcb_q    <= bus.srcb;
            idx_q     <= bus.idx;
            dst_ptr_q <= bus.dst_addr;
            rd_addr_q <= bus.src_addr;
            remain_q  <= bus.len - ADDR_W'(1);
            if (bus.len == '0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (remain_q == '0) begin
            rd_en_q <= 1'b0;
            drain_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
            remain_q  <= remain_q - ADDR_W'(1);
          end
        end

        // Two cycles let the last two words finish execute and write.
        S_DRAIN: begin
          if (drain_q) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_addr = wr_addr_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.lane_ctrl   = ctrl_q;
  assign bus.lane_srcb   = srcb_q;
  assign bus.lane_idx    = idx_q;
  assign bus.lane_rv     = bus.mem_rd_data;

`ifdef LANE_SEQ_CNT_EN
  logic [31:0] words_q;

  // Free-running count of written words; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
    end else if (wr_en_q) begin
      words_q <= words_q + 32'd1;
    end
  end

  assign words_done = words_q;
`endif

endmodule

// File: tb/tb_lane_sequencer.sv
// Directed bench for lane_sequencer: memory model, +0x0001_0001_0001_0001 lane model, timing checks.
module tb_lane_sequencer;

  localparam int unsigned ADDR_W = 8;
  localparam logic [63:0] K = 64'h0001_0001_0001_0001;

  logic clk;
  logic rst;
`ifdef LANE_SEQ_CNT_EN
  logic [31:0] words_done;
`endif

  lane_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  lane_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef LANE_SEQ_CNT_EN
    .words_done (words_done),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 1-cycle read latency, writes and bench preloads on the clock edge.
  logic [63:0]       mem [256];
  logic [63:0]       rd_data_q;
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [63:0]       pl_data;

  always @(posedge clk) begin
    if (bus.mem_rd_en) rd_data_q <= mem[bus.mem_rd_addr];
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
  end

  assign bus.mem_rd_data = rd_data_q;
  assign bus.lane_res    = bus.lane_rv + K;

  int n_chk;
  int n_pass;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Results of the last run_op, cycle numbers relative to the accept cycle T.
  int                done_at, done_cnt, busy_first, busy_last, busy_cnt;
  int                rd_cnt, wr_cnt, late_cnt;
  logic              busy_at_done, rst_snap;
  logic [ADDR_W-1:0] rd_log [32];
  logic [ADDR_W-1:0] wr_log [32];
  logic [20:0]       ctrl_seen;

  task automatic run_op(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                        input logic [ADDR_W-1:0] len, input logic [1:0] op, input logic sz,
                        input logic [15:0] sb, input logic [1:0] ix,
                        input int restart_at, input logic [ADDR_W-1:0] restart_len,
                        input int rst_at, input int ncyc);
    done_at = -1; done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
    rd_cnt = 0; wr_cnt = 0; late_cnt = 0; busy_at_done = 1'b1; rst_snap = 1'b1;
    ctrl_seen = '0;
    bus.start = 1'b1; bus.op = op; bus.size = sz; bus.srcb = sb; bus.idx = ix;
    bus.src_addr = src; bus.dst_addr = dst; bus.len = len;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      if (bus.busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      if (bus.done) begin
        done_cnt++;
        done_at = k;
        busy_at_done = bus.busy;
      end
      if (bus.mem_rd_en) begin
        if (rd_cnt < 32) rd_log[rd_cnt] = bus.mem_rd_addr;
        rd_cnt++;
      end
      if (bus.mem_wr_en) begin
        if (wr_cnt < 32) wr_log[wr_cnt] = bus.mem_wr_addr;
        wr_cnt++;
      end
      if (rst_at >= 0 && k > rst_at && (bus.mem_rd_en || bus.mem_wr_en || bus.done || bus.busy))
        late_cnt++;
      if (k == 1) begin
        bus.start = 1'b0; bus.len = 8'hAA; bus.src_addr = 8'h55; bus.dst_addr = 8'h66;
        bus.op = 2'b00; bus.size = 1'b0; bus.srcb = 16'h0; bus.idx = 2'd0;
      end
      if (k == 2) ctrl_seen = {bus.lane_ctrl, bus.lane_srcb, bus.lane_idx};
      if (k == restart_at) begin bus.start = 1'b1; bus.len = restart_len; end
      if (k == restart_at + 1) bus.start = 1'b0;
      if (k == rst_at + 1) begin
        rst = 1'b0;
        rst_snap = bus.busy | bus.done | bus.mem_rd_en | bus.mem_wr_en | (|bus.mem_rd_addr) |
                   (|bus.mem_wr_addr) | (|bus.mem_wr_data) | (|bus.lane_ctrl) |
                   (|bus.lane_srcb) | (|bus.lane_idx);
      end
      if (k == rst_at) rst = 1'b1;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.start = 1'b0; bus.op = '0; bus.size = 1'b0; bus.srcb = '0; bus.idx = '0;
    bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
    tick(); tick();

    check_eq("rst_flags", {60'd0, bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en}, 64'd0);
    check_eq("rst_addrs", {48'd0, bus.mem_rd_addr, bus.mem_wr_addr}, 64'd0);
    check_eq("rst_wdata", bus.mem_wr_data, 64'd0);
    check_eq("rst_lane", {43'd0, bus.lane_ctrl, bus.lane_srcb, bus.lane_idx}, 64'd0);
    rst = 1'b0;
    tick();

    // Basic
    for (int i = 0; i < 4; i++) poke(ADDR_W'(8'h10 + i), 64'(i + 1));
    run_op(8'h10, 8'h20, 8'd4, 2'b10, 1'b1, 16'hBEEF, 2'd3, -1, '0, -1, 10);
    check_eq("basic_done_at", 64'(done_at), 64'd7);
    check_eq("basic_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("basic_busy_at_done", 64'(busy_at_done), 64'd0);
    check_eq("basic_busy_first", 64'(busy_first), 64'd1);
    check_eq("basic_busy_last", 64'(busy_last), 64'd6);
    check_eq("basic_busy_cnt", 64'(busy_cnt), 64'd6);
    check_eq("basic_rd_cnt", 64'(rd_cnt), 64'd4);
    check_eq("basic_wr_cnt", 64'(wr_cnt), 64'd4);
    check_eq("basic_rd0", 64'(rd_log[0]), 64'h10);
    check_eq("basic_rd3", 64'(rd_log[3]), 64'h13);
    check_eq("basic_wr0", 64'(wr_log[0]), 64'h20);
    check_eq("basic_wr3", 64'(wr_log[3]), 64'h23);
    check_eq("basic_lane", 64'(ctrl_seen), 64'({3'b101, 16'hBEEF, 2'd3}));
    check_eq("basic_lane_hold", 64'({bus.lane_ctrl, bus.lane_srcb, bus.lane_idx}),
             64'({3'b101, 16'hBEEF, 2'd3}));
    check_eq("basic_mem20", mem[8'h20], 64'h0001_0001_0001_0002);
    check_eq("basic_mem21", mem[8'h21], 64'h0001_0001_0001_0003);
    check_eq("basic_mem22", mem[8'h22], 64'h0001_0001_0001_0004);
    check_eq("basic_mem23", mem[8'h23], 64'h0001_0001_0001_0005);

    // Zero length
    run_op(8'h10, 8'h30, 8'd0, 2'b01, 1'b0, 16'h1234, 2'd1, -1, '0, -1, 6);
    check_eq("zero_done_at", 64'(done_at), 64'd1);
    check_eq("zero_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("zero_busy_cnt", 64'(busy_cnt), 64'd0);
    check_eq("zero_traffic", 64'(rd_cnt + wr_cnt), 64'd0);

    // Address wrap
    poke(8'hFE, 64'h10); poke(8'hFF, 64'h20); poke(8'h00, 64'h30);
    run_op(8'hFE, 8'hFF, 8'd3, 2'b00, 1'b0, 16'h0, 2'd0, -1, '0, -1, 10);
    check_eq("wrap_rd", 64'({rd_log[0], rd_log[1], rd_log[2]}), 64'h00FEFF00);
    check_eq("wrap_wr", 64'({wr_log[0], wr_log[1], wr_log[2]}), 64'h00FF0001);
    check_eq("wrap_done_at", 64'(done_at), 64'd6);
    check_eq("wrap_memFF", mem[8'hFF], 64'h10 + K);
    check_eq("wrap_mem00", mem[8'h00], 64'h20 + K);
    check_eq("wrap_mem01", mem[8'h01], 64'h30 + K);

    // Start while busy is ignored
    run_op(8'h10, 8'h40, 8'd4, 2'b11, 1'b0, 16'h00FF, 2'd2, 2, 8'd5, -1, 14);
    check_eq("busy_wr_cnt", 64'(wr_cnt), 64'd4);
    check_eq("busy_rd_cnt", 64'(rd_cnt), 64'd4);
    check_eq("busy_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("busy_done_at", 64'(done_at), 64'd7);

    // Reset mid-operation
    run_op(8'h10, 8'h50, 8'd8, 2'b01, 1'b1, 16'hCAFE, 2'd1, -1, '0, 3, 12);
    check_eq("rstmid_outs_zero", 64'(rst_snap), 64'd0);
    check_eq("rstmid_late_activity", 64'(late_cnt), 64'd0);
    check_eq("rstmid_done_cnt", 64'(done_cnt), 64'd0);

    // Fresh operations after reset
    for (int i = 0; i < 4; i++) poke(ADDR_W'(8'h60 + i), 64'(8'h80 + i));
    run_op(8'h60, 8'h70, 8'd4, 2'b00, 1'b1, 16'h0001, 2'd0, -1, '0, -1, 10);
    check_eq("fresh_done_at", 64'(done_at), 64'd7);
    check_eq("fresh_mem70", mem[8'h70], 64'h80 + K);
    check_eq("fresh_mem73", mem[8'h73], 64'h83 + K);
    run_op(8'h70, 8'h70, 8'd3, 2'b00, 1'b1, 16'h0001, 2'd0, -1, '0, -1, 8);
    check_eq("inplace_done_at", 64'(done_at), 64'd6);
    check_eq("inplace_mem70", mem[8'h70], 64'h80 + K + K);
    check_eq("inplace_mem72", mem[8'h72], 64'h82 + K + K);
    check_eq("inplace_mem73", mem[8'h73], 64'h83 + K);
`ifdef LANE_SEQ_CNT_EN
    check_eq("words_done", 64'(words_done), 64'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
